seg7_scan_driver: RTL and testbench



---
 rtl/seg7_pkg.sv | 52 +++++
 rtl/seg7_scan_timer.sv | 53 +++++
 rtl/seg7_scan_driver.sv | 132 +++++++++++++
 tb/tb_seg7_scan_driver.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
// Shared seven-segment definitions for the scan driver and the upstream encoder.
// Segment order is a..g with bit 0 = a. Codes are active-high (1 = lit).
package seg7_pkg;

  localparam int unsigned SEG_W_DEF = 7;

  typedef logic [SEG_W_DEF-1:0] seg_code_t;

  localparam seg_code_t SEG_BLANK = '0;

  localparam seg_code_t SEG_HEX_0 = 7'h3F;
  localparam seg_code_t SEG_HEX_1 = 7'h06;
  localparam seg_code_t SEG_HEX_2 = 7'h5B;
  localparam seg_code_t SEG_HEX_3 = 7'h4F;
  localparam seg_code_t SEG_HEX_4 = 7'h66;
  localparam seg_code_t SEG_HEX_5 = 7'h6D;
  localparam seg_code_t SEG_HEX_6 = 7'h7D;
  localparam seg_code_t SEG_HEX_7 = 7'h07;
  localparam seg_code_t SEG_HEX_8 = 7'h7F;
  localparam seg_code_t SEG_HEX_9 = 7'h6F;
  localparam seg_code_t SEG_HEX_A = 7'h77;
  localparam seg_code_t SEG_HEX_B = 7'h7C;
  localparam seg_code_t SEG_HEX_C = 7'h39;
  localparam seg_code_t SEG_HEX_D = 7'h5E;
  localparam seg_code_t SEG_HEX_E = 7'h79;
  localparam seg_code_t SEG_HEX_F = 7'h71;

  // Hex nibble to active-high segment code.
  function automatic seg_code_t hex_to_seg(input logic [3:0] nib);
    seg_code_t code;
    case (nib)
      4'h0:    code = SEG_HEX_0;
      4'h1:    code = SEG_HEX_1;
      4'h2:    code = SEG_HEX_2;
      4'h3:    code = SEG_HEX_3;
      4'h4:    code = SEG_HEX_4;
      4'h5:    code = SEG_HEX_5;
      4'h6:    code = SEG_HEX_6;
      4'h7:    code = SEG_HEX_7;
      4'h8:    code = SEG_HEX_8;
      4'h9:    code = SEG_HEX_9;
      4'hA:    code = SEG_HEX_A;
      4'hB:    code = SEG_HEX_B;
      4'hC:    code = SEG_HEX_C;
      4'hD:    code = SEG_HEX_D;
      4'hE:    code = SEG_HEX_E;
      default: code = SEG_HEX_F;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/seg7_scan_timer.sv
// Digit scan timer: refresh counter, digit index, dead-zone flag, wrap strobe
// and the registered frame_tick that is high in the cycle idx becomes 0.
module seg7_scan_timer #(
  parameter  int unsigned DIGITS      = 2,
  parameter  int unsigned REFRESH_DIV = 100000,
  parameter  int unsigned DEAD_CYCLES = 2,
  localparam int unsigned CNT_W       = $clog2(REFRESH_DIV),
  localparam int unsigned IDX_W       = $clog2(DIGITS)
) (
  input  logic             clk,
  input  logic             rst,
  output logic [IDX_W-1:0] idx,
  output logic             dead,
  output logic             wrap,
  output logic             frame_tick
);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             frame_tick_q, frame_tick_d;
  logic             cnt_last, idx_last;

  // Next-state for counter and digit index; idx wraps explicitly at DIGITS-1.
  always_comb begin
    cnt_last     = (cnt_q == CNT_W'(REFRESH_DIV - 1));
    idx_last     = (idx_q == IDX_W'(DIGITS - 1));
    cnt_d        = cnt_last ? '0 : cnt_q + 1'b1;
    idx_d        = idx_q;
    if (cnt_last) begin
      idx_d = idx_last ? '0 : idx_q + 1'b1;
    end
    frame_tick_d = cnt_last && idx_last;
  end

  // Timer state registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q        <= '0;
      idx_q        <= '0;
      frame_tick_q <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      frame_tick_q <= frame_tick_d;
    end
  end

  assign idx        = idx_q;
  assign dead       = (cnt_q < CNT_W'(DEAD_CYCLES));
  assign wrap       = cnt_last && idx_last;
  assign frame_tick = frame_tick_q;

endmodule

// File: rtl/seg7_scan_driver.sv
// Double-buffered multiplexed seven-segment driver. Frames are accepted over
// valid/ready into a pending buffer and committed to the display only at the
// scan-frame wrap, so a frame is never shown half-updated.
// Optional build macro SEG7_STALE_BLANK_EN: blank the display once no frame
// has been committed for TIMEOUT_CYCLES cycles.
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter  int unsigned DIGITS         = 2,
  parameter  int unsigned SEG_W          = SEG_W_DEF,
  parameter  int unsigned REFRESH_DIV    = 100000,
  parameter  int unsigned DEAD_CYCLES    = 2,
  parameter  int unsigned TIMEOUT_CYCLES = 50_000_000,
  localparam int unsigned IDX_W          = $clog2(DIGITS)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         s_valid,
  output logic                         s_ready,
  input  logic [DIGITS-1:0][SEG_W-1:0] s_data,
  output logic [SEG_W-1:0]             seg_n,
  output logic [DIGITS-1:0]            an_n,
  output logic                         frame_tick
);

  typedef logic [DIGITS-1:0][SEG_W-1:0] frame_t;

  localparam frame_t BLANK_FRAME = {DIGITS{SEG_W'(SEG_BLANK)}};

  logic [IDX_W-1:0]  idx;
  logic              dead, wrap;
  logic              xfer, commit;

  frame_t            pbuf_q, pbuf_d;
  frame_t            display_q, display_d;
  logic              pending_q, pending_d;
  logic              s_ready_q, s_ready_d;
  logic [SEG_W-1:0]  seg_n_q, seg_n_d;
  logic [DIGITS-1:0] an_n_q, an_n_d;

`ifdef SEG7_STALE_BLANK_EN
  localparam int unsigned STALE_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [STALE_W-1:0] stale_q, stale_d;
`else
  // Timeout has no effect without stale blanking; kept so both builds share one interface.
  if (TIMEOUT_CYCLES == 0) begin : g_timeout_unused
  end
`endif

  seg7_scan_timer #(
    .DIGITS      (DIGITS),
    .REFRESH_DIV (REFRESH_DIV),
    .DEAD_CYCLES (DEAD_CYCLES)
  ) u_timer (
    .clk        (clk),
    .rst        (rst),
    .idx        (idx),
    .dead       (dead),
    .wrap       (wrap),
    .frame_tick (frame_tick)
  );

  // Handshake capture, wrap-time commit and optional stale blanking.
  always_comb begin
    xfer      = s_valid && s_ready_q;
    commit    = wrap && pending_q;
    pbuf_d    = pbuf_q;
    pending_d = pending_q;
    display_d = display_q;
    if (xfer) begin
      pbuf_d    = s_data;
      pending_d = 1'b1;
    end else if (commit) begin
      display_d = pbuf_q;
      pending_d = 1'b0;
    end
    // Registered ready keeps s_ready low in the first cycle after reset.
    s_ready_d = ~pending_d;
`ifdef SEG7_STALE_BLANK_EN
    if (commit) begin
      stale_d = '0;
    end else if (stale_q != STALE_W'(TIMEOUT_CYCLES)) begin
      stale_d = stale_q + 1'b1;
    end else begin
      stale_d = stale_q;
    end
    if (!commit && (stale_d == STALE_W'(TIMEOUT_CYCLES))) begin
      display_d = BLANK_FRAME;
    end
`endif
  end

  // Pin drive for the slot the timer currently points at; blank in the dead zone.
  always_comb begin
    seg_n_d = '1;
    an_n_d  = '1;
    if (!dead) begin
      seg_n_d = ~display_q[idx];
      an_n_d  = ~(DIGITS'(1) << idx);
    end
  end

  // Buffer, handshake and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pbuf_q    <= BLANK_FRAME;
      display_q <= BLANK_FRAME;
      pending_q <= 1'b0;
      s_ready_q <= 1'b0;
      seg_n_q   <= '1;
      an_n_q    <= '1;
`ifdef SEG7_STALE_BLANK_EN
      stale_q   <= '0;
`endif
    end else begin
      pbuf_q    <= pbuf_d;
      display_q <= display_d;
      pending_q <= pending_d;
      s_ready_q <= s_ready_d;
      seg_n_q   <= seg_n_d;
      an_n_q    <= an_n_d;
`ifdef SEG7_STALE_BLANK_EN
      stale_q   <= stale_d;
`endif
    end
  end

  assign s_ready = s_ready_q;
  assign seg_n   = seg_n_q;
  assign an_n    = an_n_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Self-checking bench for seg7_scan_driver (DIGITS=2, REFRESH_DIV=4,
// DEAD_CYCLES=1, TIMEOUT_CYCLES=40). Accepted frames are queued by a
// reference model and popped at the frame wrap; every cycle the pins are
// compared with the model, plus directed checks on the key timing points.
module tb_seg7_scan_driver;

  localparam int unsigned DIGITS    = 2;
  localparam int unsigned SEG_W     = 7;
  localparam int unsigned RD        = 4;
  localparam int unsigned DEAD      = 1;
  localparam int unsigned TO        = 40;
  localparam int unsigned FRAME_LEN = RD * DIGITS;

  typedef logic [DIGITS-1:0][SEG_W-1:0] frame_t;

  localparam frame_t F10 = {7'h06, 7'h3F};
  localparam frame_t FA  = {7'h5B, 7'h4F};
  localparam frame_t FB  = {7'h66, 7'h6D};
  localparam frame_t FC  = {7'h7D, 7'h07};
  localparam frame_t FD  = {7'h7F, 7'h6F};

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              s_valid = 1'b0;
  logic              s_ready;
  frame_t            s_data = '0;
  logic [SEG_W-1:0]  seg_n;
  logic [DIGITS-1:0] an_n;
  logic              frame_tick;

  int n_chk  = 0;
  int n_fail = 0;

  seg7_scan_driver #(
    .DIGITS         (DIGITS),
    .SEG_W          (SEG_W),
    .REFRESH_DIV    (RD),
    .DEAD_CYCLES    (DEAD),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .s_valid    (s_valid),
    .s_ready    (s_ready),
    .s_data     (s_data),
    .seg_n      (seg_n),
    .an_n       (an_n),
    .frame_tick (frame_tick)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic logic [SEG_W-1:0] seg_of(input frame_t f, input int d);
    return ~f[d];
  endfunction

  // ---------------- reference model ----------------
  frame_t            pend_q[$];
  frame_t            m_disp;
  logic [SEG_W-1:0]  m_seg;
  logic [DIGITS-1:0] m_an;
  logic              m_tick;
  logic              m_ready;
  int unsigned       m_k;
  int unsigned       m_stale;

  always @(posedge clk or posedge rst) begin
    int unsigned       cnt, idx, stale_n;
    bit                wrap, had_pend, xfer, cmt;
    frame_t            disp_n;
    logic [SEG_W-1:0]  seg_nx;
    logic [DIGITS-1:0] an_nx;
    if (rst) begin
      pend_q.delete();
      m_disp  <= '0;
      m_seg   <= '1;
      m_an    <= '1;
      m_tick  <= 1'b0;
      m_ready <= 1'b0;
      m_k     <= 0;
      m_stale <= 0;
    end else begin
      cnt   = m_k % RD;
      idx   = (m_k / RD) % DIGITS;
      seg_nx = '1;
      an_nx  = '1;
      if (cnt >= DEAD) begin
        seg_nx     = ~m_disp[idx];
        an_nx[idx] = 1'b0;
      end
      wrap     = (m_k % FRAME_LEN) == FRAME_LEN - 1;
      had_pend = pend_q.size() != 0;
      xfer     = s_valid && m_ready;
      cmt      = wrap && had_pend;
      disp_n   = m_disp;
      if (cmt) disp_n = pend_q.pop_front();
      if (xfer) pend_q.push_back(s_data);
      stale_n = cmt ? 0 : ((m_stale < TO) ? m_stale + 1 : m_stale);
`ifdef SEG7_STALE_BLANK_EN
      if (!cmt && stale_n == TO) disp_n = '0;
`endif
      m_stale <= stale_n;
      m_seg   <= seg_nx;
      m_an    <= an_nx;
      m_tick  <= wrap;
      m_disp  <= disp_n;
      m_ready <= (pend_q.size() == 0);
      m_k     <= (m_k + 1) % FRAME_LEN;
    end
  end

  // Per-cycle comparison of the pins against the model.
  always @(negedge clk) begin
    if (!rst) begin
      chk("seg_n", seg_n, m_seg);
      chk("an_n", an_n, m_an);
      chk("frame_tick", frame_tick, m_tick);
      chk("s_ready", s_ready, m_ready);
      chk("an_onehot", ($countones(~an_n) <= 1), 1);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic wait_commit(input string tag, input int max);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(frame_tick === 1'b1 && s_ready === 1'b1) && n < max);
    chk(tag, frame_tick && s_ready, 1);
  endtask

  task automatic wait_slot(input string tag, input int d, input int max);
    logic [DIGITS-1:0] mask;
    int n = 0;
    mask    = '1;
    mask[d] = 1'b0;
    do begin
      @(negedge clk);
      n++;
    end while (an_n !== mask && n < max);
    chk(tag, an_n, mask);
  endtask

  task automatic send(input string tag, input frame_t f, input int max, output logic tick_seen);
    bit ok = 0;
    int n = 0;
    tick_seen = 1'b0;
    @(posedge clk);
    #1;
    s_data  = f;
    s_valid = 1'b1;
    while (!ok && n < max) begin
      @(negedge clk);
      if (s_ready === 1'b1) begin
        ok        = 1;
        tick_seen = frame_tick;
      end
      @(posedge clk);
      #1;
      n++;
    end
    s_valid = 1'b0;
    chk({tag, "_accepted"}, ok, 1);
    chk({tag, "_ready_drop"}, s_ready, 0);
  endtask

  // Called at the negedge where frame_tick is seen; checks the next full period.
  task automatic check_frame(input string tag, input frame_t f);
    for (int i = 1; i <= int'(FRAME_LEN); i++) begin
      int unsigned       k, cnt, d;
      logic [SEG_W-1:0]  e_seg;
      logic [DIGITS-1:0] e_an;
      k     = i - 1;
      cnt   = k % RD;
      d     = k / RD;
      e_seg = '1;
      e_an  = '1;
      if (cnt >= DEAD) begin
        e_seg   = seg_of(f, d);
        e_an[d] = 1'b0;
      end
      @(negedge clk);
      chk({tag, "_seg"}, seg_n, e_seg);
      chk({tag, "_an"}, an_n, e_an);
      chk({tag, "_tick"}, frame_tick, (i == int'(FRAME_LEN)));
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic tk;
    #1 rst = 1'b1;
    #1;
    chk("rst_seg_n", seg_n, 7'h7F);
    chk("rst_an_n", an_n, 2'b11);
    chk("rst_s_ready", s_ready, 0);
    chk("rst_frame_tick", frame_tick, 0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk);
    #1;
    chk("ready_after_rst", s_ready, 1);
    wait_slot("blank_slot0", 0, 20);
    chk("blank_seg0", seg_n, 7'h7F);
    wait_slot("blank_slot1", 1, 20);
    chk("blank_seg1", seg_n, 7'h7F);

    // Basic scan of "10".
    send("f10", F10, 20, tk);
    wait_commit("f10_commit", 20);
    check_frame("f10", F10);

    // Backpressure: B held while A pending.
    send("fa", FA, 20, tk);
    send("fb", FB, 40, tk);
    chk("fb_accept_after_commit", tk, 1);
    @(negedge clk);
    @(negedge clk);
    chk("fa_shown_an", an_n, 2'b10);
    chk("fa_shown_seg", seg_n, seg_of(FA, 0));
    wait_commit("fb_commit", 20);
    check_frame("fb", FB);

    // Frame presented exactly in the wrap cycle.
    repeat (FRAME_LEN - 1) @(negedge clk);
    s_data  = FC;
    s_valid = 1'b1;
    @(posedge clk);
    #1 s_valid = 1'b0;
    chk("fc_wrap_accept", s_ready, 0);
    repeat (3) @(negedge clk);
    chk("fc_old_an", an_n, 2'b10);
    chk("fc_old_seg", seg_n, seg_of(FB, 0));
    repeat (FRAME_LEN) @(negedge clk);
    chk("fc_new_an", an_n, 2'b10);
    chk("fc_new_seg", seg_n, seg_of(FC, 0));

    // Reset while a frame is pending.
    wait_commit("fc_commit_seen", 20);
    send("fd", FD, 20, tk);
    wait_slot("fd_slot", 0, 20);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_seg", seg_n, 7'h7F);
    chk("async_rst_an", an_n, 2'b11);
    chk("async_rst_ready", s_ready, 0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk);
    #1;
    chk("ready_after_mid_rst", s_ready, 1);
    repeat (3 * FRAME_LEN) begin
      @(negedge clk);
      if (an_n !== 2'b11) chk("no_discarded_frame", seg_n, 7'h7F);
    end

    // Long hold after a commit.
    send("f10b", F10, 20, tk);
    wait_commit("f10b_commit", 20);
`ifdef SEG7_STALE_BLANK_EN
    repeat (TO - 2) @(negedge clk);
    chk("stale_before_seg", seg_n, 7'h79);
    chk("stale_before_an", an_n, 2'b01);
    repeat (4) @(negedge clk);
    chk("stale_blank_seg", seg_n, 7'h7F);
    chk("stale_blank_an", an_n, 2'b10);
`else
    repeat (200) @(negedge clk);
    chk("hold_d1_seg", seg_n, 7'h79);
    chk("hold_d1_an", an_n, 2'b01);
    repeat (2) @(negedge clk);
    chk("hold_d0_seg", seg_n, 7'h40);
    chk("hold_d0_an", an_n, 2'b10);
`endif

    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end

endmodule
